video_timing_gen: RTL
=====================

# video_timing_gen

Generates the raster timing that drives `hdmi_transmitter_core`: horizontal/vertical counters, sync pulses, data-enable, pixel coordinates and frame/line markers, all in the pixel clock domain. It sits directly upstream of the core and, optionally, supplies an internal colour-bar test pattern as the pixel source. It includes an enable handshake so frames always start and stop on frame boundaries.

## Interface
Parameters:
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, hsync pulse width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vsync pulse width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `H_POL`, 0, hsync active level (0 = active-low)
- `V_POL`, 0, vsync active level (0 = active-low)

Ports:
- `clk` in 1: pixel clock; one clock, all logic on its rising edge
- `rst` in 1: synchronous, active-high reset
- `i_en` in 1: run request
- `o_busy` out 1: high whenever the state is not IDLE
- `o_hsync` out 1: horizontal sync at `H_POL` level during the pulse
- `o_vsync` out 1: vertical sync at `V_POL` level during the pulse
- `o_de` out 1: active-video flag
- `o_x` out 12: pixel column, valid when `o_de` is high
- `o_y` out 12: pixel row, valid when `o_de` is high
- `o_sof` out 1: one-cycle pulse at pixel (0,0)
- `o_eol` out 1: one-cycle pulse at the last active pixel of each active line
- `o_rgb` out 24: {R,G,B} test-pattern pixel

## Operation
- `H_TOTAL` = `H_ACTIVE`+`H_FP`+`H_SYNC`+`H_BP` (800). `V_TOTAL` = `V_ACTIVE`+`V_FP`+`V_SYNC`+`V_BP` (525).
- Counters: `hc` (0..`H_TOTAL`-1) and `vc` (0..`V_TOTAL`-1). `hc` wraps to 0 at `H_TOTAL`-1. `vc` increments on the `hc` wrap and wraps to 0 at `V_TOTAL`-1.
- Line order: active, then FP, then sync, then BP. The same order applies per frame.
- Sync pulse positions:
  - hsync asserted for `H_ACTIVE`+`H_FP` ≤ hc < `H_ACTIVE`+`H_FP`+`H_SYNC` (656..751).
  - vsync asserted for lines 490..491.
- Output conditions:
  - `o_de` = hc<`H_ACTIVE` && vc<`V_ACTIVE`.
  - `o_sof` = hc==0 && vc==0.
  - `o_eol` = hc==`H_ACTIVE`-1 && vc<`V_ACTIVE`.
- State machine (IDLE, RUN, DRAIN):
  - IDLE: counters held at 0; syncs at their inactive levels; `o_de`/`o_sof`/`o_eol` = 0. If `i_en`=1, go to RUN with hc=vc=0.
  - RUN: counters advance every cycle. If `i_en`=0, go to DRAIN.
  - DRAIN: counters continue advancing. At hc=`H_TOTAL`-1 and vc=`V_TOTAL`-1, go to IDLE with counters at 0. If `i_en`=1, return to RUN without disturbing the counters.
  - Simultaneous `i_en` fall and frame end in RUN: go to DRAIN; the next frame completes in full.
- Reset (synchronous, any cycle, including mid-frame): state=IDLE, hc=vc=0. Output reset values: `o_hsync`=~`H_POL`, `o_vsync`=~`V_POL`, `o_de`=0, `o_x`=0, `o_y`=0, `o_sof`=0, `o_eol`=0, `o_rgb`=0, `o_busy`=0.
- `o_x`/`o_y` = hc/vc zero-extended to 12 bits. Parameter totals must be ≤4096; an elaboration check fails otherwise.

## Timing
- All outputs are registered. The outputs for counter value (hc,vc) appear one cycle after the counters hold that value.
- `i_en` sampled high in IDLE at edge k → `o_busy` is high after edge k+1 → `o_sof`/`o_de` (pixel 0,0) are high after edge k+2.
- Line period is exactly `H_TOTAL` cycles. Frame period is exactly `H_TOTAL`×`V_TOTAL` cycles (420000).
- `o_rgb` is aligned to the same cycle as `o_de`. No extra latency is allowed.

## Configuration
- Macro: `VTG_PATTERN_EN`.
- Defined:
  - `o_rgb` carries 8 vertical colour bars, each `H_ACTIVE`/8 wide; the last bar absorbs the remainder.
  - Bar order, left to right: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - `o_rgb` = 0 whenever `o_de`=0.
- Undefined: `o_rgb` is tied to 0 and no bar logic is synthesised. The port remains so the top-level wiring does not change.

## Structure
- Package `video_timing_pkg`:
  - state enum (IDLE/RUN/DRAIN)
  - 24-bit colour constants for the eight bars
  - VGA default timing localparams
  - a packed timing struct for future resolution selection
- Sub-module `color_bar_gen`: takes the registered hc and de, and produces `o_rgb` aligned to `o_de`. It is instantiated only under `VTG_PATTERN_EN`.

## Test plan
- Reset, then `i_en`=1 at edge k → `o_sof` at edge k+2 with `o_x`=0 and `o_y`=0, `o_busy`=1. Reset value of every output checked before edge k.
- One full line → `o_hsync` low for exactly 96 cycles starting at x=656; `o_de` high for 640 cycles; `o_eol` at x=639; period 800 cycles.
- One full frame → `o_vsync` low for 2 lines (lines 490–491); 307200 `o_de` cycles; next `o_sof` exactly 420000 cycles later.
- `i_en` dropped mid-frame (line 100) → frame completes; IDLE entered after (799,524); `o_busy`=0; no further `o_sof`. Re-raising `i_en` in DRAIN → no gap before the next `o_sof`.
- `rst` asserted at pixel (320,240) → next cycle all outputs at reset values and `o_busy`=0. Restart produces a clean frame from (0,0).
- With `VTG_PATTERN_EN`: `o_rgb`=FFFFFF at x=0, FFFF00 at x=80, 000000 at x=639, and 0 in blanking. Without the macro: `o_rgb`=0 always.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types and constants for the raster timing generator.
// Optional feature: colour-bar test pattern, enabled by the VTG_PATTERN_EN macro.
package video_timing_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN
  } vtg_state_e;

  // 640x480 @ 60 Hz default raster
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Bar colours as {R,G,B}, left to right
  localparam logic [23:0] RGB_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] RGB_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] RGB_CYAN    = 24'h00FFFF;
  localparam logic [23:0] RGB_GREEN   = 24'h00FF00;
  localparam logic [23:0] RGB_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] RGB_RED     = 24'hFF0000;
  localparam logic [23:0] RGB_BLUE    = 24'h0000FF;
  localparam logic [23:0] RGB_BLACK   = 24'h000000;

  // Reserved for run-time resolution selection
  typedef struct packed {
    logic [11:0] h_active;
    logic [11:0] h_fp;
    logic [11:0] h_sync;
    logic [11:0] h_bp;
    logic [11:0] v_active;
    logic [11:0] v_fp;
    logic [11:0] v_sync;
    logic [11:0] v_bp;
    logic        h_pol;
    logic        v_pol;
  } vtg_timing_t;

  function automatic logic [23:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return RGB_WHITE;
      3'd1:    return RGB_YELLOW;
      3'd2:    return RGB_CYAN;
      3'd3:    return RGB_GREEN;
      3'd4:    return RGB_MAGENTA;
      3'd5:    return RGB_RED;
      3'd6:    return RGB_BLUE;
      default: return RGB_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_gen_color_bar.sv
// color_bar_gen: eight vertical colour bars across the active width; the
// last bar absorbs any remainder. Only built when VTG_PATTERN_EN is defined.
`ifdef VTG_PATTERN_EN
module color_bar_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hc,
  input  logic        de,
  output logic [23:0] rgb
);

  localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;

  logic [2:0] bar_idx;

  // Bar index by threshold compare; scanning downwards leaves the lowest match
  always_comb begin
    bar_idx = 3'd7;
    for (int b = 6; b >= 0; b--) begin
      if (int'(hc) < (b + 1) * BAR_W) bar_idx = 3'(b);
    end
  end

  // p0 -> p1: registered alongside the timing outputs so rgb lines up with de
  always_ff @(posedge clk) begin
    if (rst) rgb <= '0;
    else     rgb <= de ? bar_color(bar_idx) : '0;
  end

endmodule
`endif

// File: rtl/video_timing_gen.sv
// video_timing_gen: raster counters, syncs, data-enable, coordinates and
// frame/line markers for the HDMI core. Starts and stops on frame boundaries.
// Optional feature: VTG_PATTERN_EN adds a colour-bar source on o_rgb.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP,
  parameter int H_POL    = 0,
  parameter int V_POL    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  output logic        o_busy,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [11:0] o_x,
  output logic [11:0] o_y,
  output logic        o_sof,
  output logic        o_eol,
  output logic [23:0] o_rgb
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;
  localparam logic HS_ACT = (H_POL != 0);
  localparam logic VS_ACT = (V_POL != 0);

  // Counters are 12 bits wide; larger rasters cannot be represented
  if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_timing
    $error("video_timing_gen: H_TOTAL/V_TOTAL must not exceed 4096");
  end

  vtg_state_e  state_p0, state_nx;
  logic [11:0] hc_p0, vc_p0;
  logic        busy_p1;
  logic        line_end, frame_end, live;
  logic        de_nx, hs_nx, vs_nx, sof_nx, eol_nx;

  assign line_end  = (int'(hc_p0) == H_TOTAL - 1);
  assign frame_end = line_end && (int'(vc_p0) == V_TOTAL - 1);
  // Counters move only once busy has been published, giving one arming cycle
  assign live      = (state_p0 != IDLE) && busy_p1;

  assign de_nx  = live && (int'(hc_p0) < H_ACTIVE) && (int'(vc_p0) < V_ACTIVE);
  assign hs_nx  = live && (int'(hc_p0) >= HS_START) && (int'(hc_p0) < HS_END);
  assign vs_nx  = live && (int'(vc_p0) >= VS_START) && (int'(vc_p0) < VS_END);
  assign sof_nx = live && (hc_p0 == 12'd0) && (vc_p0 == 12'd0);
  assign eol_nx = live && (int'(hc_p0) == H_ACTIVE - 1) && (int'(vc_p0) < V_ACTIVE);

  // Run/stop control: a stop request is honoured only at the end of a frame
  always_comb begin
    state_nx = state_p0;
    case (state_p0)
      IDLE:    if (i_en) state_nx = RUN;
      RUN:     if (!i_en) state_nx = DRAIN;
      DRAIN: begin
        if (i_en)           state_nx = RUN;
        else if (frame_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // p0: state and raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      hc_p0    <= '0;
      vc_p0    <= '0;
    end else begin
      state_p0 <= state_nx;
      if (state_p0 == IDLE) begin
        hc_p0 <= '0;
        vc_p0 <= '0;
      end else if (busy_p1) begin
        if (line_end) begin
          hc_p0 <= '0;
          vc_p0 <= frame_end ? 12'd0 : vc_p0 + 12'd1;
        end else begin
          hc_p0 <= hc_p0 + 12'd1;
        end
      end
    end
  end

  // p0 -> p1: registered timing outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_p1 <= 1'b0;
      o_hsync <= ~HS_ACT;
      o_vsync <= ~VS_ACT;
      o_de    <= 1'b0;
      o_x     <= '0;
      o_y     <= '0;
      o_sof   <= 1'b0;
      o_eol   <= 1'b0;
    end else begin
      busy_p1 <= (state_p0 != IDLE);
      o_hsync <= hs_nx ? HS_ACT : ~HS_ACT;
      o_vsync <= vs_nx ? VS_ACT : ~VS_ACT;
      o_de    <= de_nx;
      o_x     <= hc_p0;
      o_y     <= vc_p0;
      o_sof   <= sof_nx;
      o_eol   <= eol_nx;
    end
  end

  assign o_busy = busy_p1;

`ifdef VTG_PATTERN_EN
  color_bar_gen #(
    .H_ACTIVE (H_ACTIVE)
  ) u_color_bar (
    .clk (clk),
    .rst (rst),
    .hc  (hc_p0),
    .de  (de_nx),
    .rgb (o_rgb)
  );
`else
  assign o_rgb = '0;
`endif

endmodule
